// File: rtl/miller_pcd_tx.sv
// miller_pcd_tx
//   Reader-side ISO/IEC 14443-A transmitter. Serialises bytes from a
//   valid/ready stream into a modified-Miller pause stream. It adds SOF,
//   odd parity after every byte, and EOF. It also supports 7-bit short frames.
//
// Ports
//   clk, resetn          clock; synchronous active-low reset
//   tx_data[7:0]         byte to send, LSB first
//   tx_valid / tx_ready  byte handshake (accept on valid && ready)
//   tx_last              byte closes the frame
//   tx_short             first byte only: 7-bit short frame, no parity
//   miller_out           registered line state, 1 = carrier, 0 = pause
//   busy                 frame in progress
//   done                 one-cycle pulse after a normally completed frame
//   underrun             one-cycle pulse when a frame is cut short because
//                        the next byte did not arrive during parity
module miller_pcd_tx #(
    parameter int unsigned BIT_CLKS   = 128,
    parameter int unsigned PAUSE_CLKS = 32
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    input  logic       tx_short,
    output logic       tx_ready,
    output logic       miller_out,
    output logic       busy,
    output logic       done,
    output logic       underrun
);

    localparam int unsigned CW     = $clog2(BIT_CLKS);
    localparam logic [CW-1:0] C_LAST = CW'(BIT_CLKS - 1);
    localparam int unsigned HALF   = BIT_CLKS / 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SOF,
        S_DATA,
        S_PAR,
        S_EOF0,
        S_EOF1
    } state_t;

    typedef enum logic [1:0] {
        SYM_Y,
        SYM_Z,
        SYM_X
    } sym_t;

    state_t        state, state_nxt;
    sym_t          sym, sym_nxt;
    logic [CW-1:0] c, c_nxt;
    logic [2:0]    bit_idx, bit_idx_nxt;
    logic [7:0]    data_r, data_nxt;
    logic          last_r, last_nxt;
    logic          short_r, short_nxt;
    logic          prev_bit, prev_nxt;
    logic          got_r, got_nxt;
    logic          abort_r, abort_nxt;
    logic          miller_nxt, done_nxt, underrun_nxt;
    logic          accept, period_end, par_bit, next_bit;
    logic [2:0]    last_idx;
    logic [7:0]    byte_cur;

    // Modified-Miller symbol for one logic bit given the bit sent before it.
    function automatic sym_t code_bit(input logic b, input logic prev);
        if (b)
            return SYM_X;
        else if (prev)
            return SYM_Y;
        else
            return SYM_Z;
    endfunction

    // Line level for a symbol at bit-period position cnt.
    function automatic logic sym_level(input sym_t s, input logic [CW-1:0] cnt);
        int unsigned ci;
        ci = 32'(cnt);
        case (s)
            SYM_Z:   return !(ci < PAUSE_CLKS);
            SYM_X:   return !(ci >= HALF && ci < HALF + PAUSE_CLKS);
            default: return 1'b1;
        endcase
    endfunction

    assign tx_ready   = (state == S_IDLE) || (state == S_PAR && !last_r && !got_r);
    assign busy       = (state != S_IDLE);
    assign accept     = tx_valid && tx_ready;
    assign period_end = (c == C_LAST);
    assign last_idx   = short_r ? 3'd6 : 3'd7;
    assign par_bit    = ~^data_r;
    assign next_bit   = data_r[bit_idx + 3'd1];
    // A byte taken in the final PAR cycle must feed bit 0 straight away.
    assign byte_cur   = (state == S_PAR && accept) ? tx_data : data_r;

    always_comb begin
        state_nxt    = state;
        sym_nxt      = sym;
        bit_idx_nxt  = bit_idx;
        data_nxt     = data_r;
        last_nxt     = last_r;
        short_nxt    = short_r;
        prev_nxt     = prev_bit;
        got_nxt      = got_r;
        abort_nxt    = abort_r;
        done_nxt     = 1'b0;
        underrun_nxt = 1'b0;
        if (state == S_IDLE)
            c_nxt = '0;
        else if (period_end)
            c_nxt = '0;
        else
            c_nxt = c + 1'b1;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    data_nxt    = tx_data;
                    last_nxt    = tx_last;
                    short_nxt   = tx_short;
                    state_nxt   = S_SOF;
                    sym_nxt     = SYM_Z;
                    prev_nxt    = 1'b0;
                    bit_idx_nxt = '0;
                    got_nxt     = 1'b0;
                    abort_nxt   = 1'b0;
                end
            end
            S_SOF: begin
                if (period_end) begin
                    state_nxt   = S_DATA;
                    bit_idx_nxt = '0;
                    sym_nxt     = code_bit(data_r[0], prev_bit);
                    prev_nxt    = data_r[0];
                end
            end
            S_DATA: begin
                if (period_end) begin
                    if (bit_idx == last_idx) begin
                        if (short_r) begin
                            state_nxt = S_EOF0;
                            sym_nxt   = code_bit(1'b0, prev_bit);
                            prev_nxt  = 1'b0;
                        end else begin
                            state_nxt = S_PAR;
                            sym_nxt   = code_bit(par_bit, prev_bit);
                            prev_nxt  = par_bit;
                            got_nxt   = 1'b0;
                        end
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                        sym_nxt     = code_bit(next_bit, prev_bit);
                        prev_nxt    = next_bit;
                    end
                end
            end
            S_PAR: begin
                if (accept) begin
                    data_nxt = tx_data;
                    last_nxt = tx_last;
                    got_nxt  = 1'b1;
                end
                if (period_end) begin
                    if (got_r || accept) begin
                        state_nxt   = S_DATA;
                        bit_idx_nxt = '0;
                        sym_nxt     = code_bit(byte_cur[0], prev_bit);
                        prev_nxt    = byte_cur[0];
                        got_nxt     = 1'b0;
                    end else begin
                        state_nxt = S_EOF0;
                        sym_nxt   = code_bit(1'b0, prev_bit);
                        prev_nxt  = 1'b0;
                        if (!last_r) begin
                            underrun_nxt = 1'b1;
                            abort_nxt    = 1'b1;
                        end
                    end
                end
            end
            S_EOF0: begin
                if (period_end) begin
                    state_nxt = S_EOF1;
                    sym_nxt   = SYM_Y;
                end
            end
            S_EOF1: begin
                if (period_end) begin
                    state_nxt = S_IDLE;
                    sym_nxt   = SYM_Y;
                    done_nxt  = !abort_r;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                sym_nxt   = SYM_Y;
            end
        endcase

        // Output is registered, so it is derived from next-cycle state.
        if (state_nxt == S_IDLE)
            miller_nxt = 1'b1;
        else
            miller_nxt = sym_level(sym_nxt, c_nxt);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= S_IDLE;
            sym        <= SYM_Y;
            c          <= '0;
            bit_idx    <= '0;
            data_r     <= '0;
            last_r     <= 1'b0;
            short_r    <= 1'b0;
            prev_bit   <= 1'b0;
            got_r      <= 1'b0;
            abort_r    <= 1'b0;
            miller_out <= 1'b1;
            done       <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state      <= state_nxt;
            sym        <= sym_nxt;
            c          <= c_nxt;
            bit_idx    <= bit_idx_nxt;
            data_r     <= data_nxt;
            last_r     <= last_nxt;
            short_r    <= short_nxt;
            prev_bit   <= prev_nxt;
            got_r      <= got_nxt;
            abort_r    <= abort_nxt;
            miller_out <= miller_nxt;
            done       <= done_nxt;
            underrun   <= underrun_nxt;
        end
    end

endmodule

// File: tb/tb_miller_pcd_tx.sv
// tb_miller_pcd_tx
//   Scoreboard bench for miller_pcd_tx. Stimulus pushes the hand-derived
//   Miller symbol string and the end-of-frame status for each frame. A
//   monitor decodes every bit period of miller_out into Z/X/Y and checks it
//   against the queue. At frame end it checks length, done and underrun.
module tb_miller_pcd_tx;

    localparam int BC = 128;
    localparam int PC = 32;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_last = 1'b0;
    logic       tx_short = 1'b0;
    logic       tx_ready, miller_out, busy, done, underrun;

    miller_pcd_tx #(.BIT_CLKS(BC), .PAUSE_CLKS(PC)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_last    (tx_last),
        .tx_short   (tx_short),
        .tx_ready   (tx_ready),
        .miller_out (miller_out),
        .busy       (busy),
        .done       (done),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    int frames_done = 0;

    typedef struct {
        bit ignore;
        bit exp_done;
        int exp_under;
        int nper;
    } frame_t;

    frame_t frm_q[$];
    byte    sym_q[$];

    function automatic void chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void push_frame(input string s, input bit ign, input bit d, input int u);
        frame_t f;
        for (int i = 0; i < s.len(); i++) sym_q.push_back(s[i]);
        f.ignore = ign;
        f.exp_done = d;
        f.exp_under = u;
        f.nper = s.len();
        frm_q.push_back(f);
    endfunction

    // Monitor: symbol decode and end-of-frame checks.
    initial begin : monitor
        logic [BC-1:0] zpat, xpat, w;
        int     pos, nper, ucnt;
        bit     in_frame;
        frame_t f;
        byte    es, as;
        pos = 0; nper = 0; ucnt = 0; in_frame = 0; w = '1;
        f = '{1'b1, 1'b0, 0, 0};
        for (int i = 0; i < BC; i++) begin
            zpat[i] = (i < PC) ? 1'b0 : 1'b1;
            xpat[i] = (i >= BC/2 && i < BC/2 + PC) ? 1'b0 : 1'b1;
        end
        forever begin
            @(negedge clk);
            if (!in_frame && busy === 1'b1) begin
                in_frame = 1; pos = 0; nper = 0; ucnt = 0;
                if (frm_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_frame: got frame expected none (cycle %0d)", cyc);
                    f = '{1'b1, 1'b0, 0, 0};
                end else begin
                    f = frm_q.pop_front();
                end
            end
            if (in_frame && busy === 1'b1) begin
                w[pos] = miller_out;
                if (underrun === 1'b1) ucnt++;
                pos++;
                if (pos == BC) begin
                    pos = 0;
                    nper++;
                    if (!f.ignore) begin
                        if (w == '1)        as = "Y";
                        else if (w == zpat) as = "Z";
                        else if (w == xpat) as = "X";
                        else                as = "?";
                        es = (sym_q.size() > 0) ? sym_q.pop_front() : "-";
                        total++;
                        if (as != es) begin
                            bad++;
                            $display("FAIL symbol %0d: got %c expected %c (cycle %0d)", nper, as, es, cyc);
                        end
                    end
                end
            end else if (in_frame) begin
                in_frame = 0;
                if (!f.ignore) begin
                    chk("frame_periods", nper, f.nper);
                    chk("frame_align", pos, 0);
                end
                chk("done_at_end", int'(done), int'(f.exp_done));
                chk("underrun_pulses", ucnt, f.exp_under);
                frames_done++;
            end else if (resetn === 1'b1) begin
                chk("idle_no_done", int'(done), 0);
            end
        end
    end

    task automatic send(input logic [7:0] d, input bit last, input bit sh, input bit keep,
                        output int unsigned acc);
        int n;
        tx_data = d; tx_last = last; tx_short = sh; tx_valid = 1'b1;
        n = 0;
        while (tx_ready !== 1'b1 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (tx_ready !== 1'b1) begin
            total++; bad++;
            $display("FAIL ready_timeout: got tx_ready=%b expected 1", tx_ready);
        end
        acc = cyc;
        @(posedge clk);
        #1;
        if (!keep) tx_valid = 1'b0;
    endtask

    task automatic wait_frames(input int k);
        int n;
        n = 0;
        while (frames_done < k && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("frames_completed", frames_done, k);
        repeat (4) @(negedge clk);
    endtask

    initial begin : stim
        int unsigned a1, a2;
        int n;
        repeat (3) @(negedge clk);
        chk("rst_miller", int'(miller_out), 1);
        chk("rst_ready", int'(tx_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_underrun", int'(underrun), 0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // REQA short frame
        push_frame("ZZXXYZXYZY", 0, 1, 0);
        send(8'h26, 1, 1, 0, a1);
        wait_frames(1);

        // Two-byte standard frame, valid held high
        push_frame("ZXXYZXYZXXYZZZZXYZZZY", 0, 1, 0);
        send(8'h93, 0, 0, 1, a1);
        send(8'h20, 1, 0, 0, a2);
        chk("std_accept_gap", int'(a2 - a1), 1153);
        wait_frames(2);

        // Underrun
        push_frame("ZZZZZXYXYXYY", 0, 0, 1);
        send(8'h50, 0, 0, 0, a1);
        wait_frames(3);

        // Late accept in the final PAR cycle
        push_frame("ZZZZZXYXYXYXXYZXYZZZY", 0, 1, 0);
        send(8'h50, 0, 0, 0, a1);
        while (cyc < a1 + 1280) @(negedge clk);
        chk("late_ready", int'(tx_ready), 1);
        send(8'h26, 1, 0, 0, a2);
        chk("late_accept_gap", int'(a2 - a1), 1280);
        wait_frames(4);

        // Reset during DATA bit 3 (Z pause) of 0x93
        push_frame("", 1, 0, 0);
        send(8'h93, 0, 0, 0, a1);
        while (cyc < a1 + 523) @(negedge clk);
        chk("pre_rst_miller_low", int'(miller_out), 0);
        chk("pre_rst_busy", int'(busy), 1);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        chk("midrst_miller", int'(miller_out), 1);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_ready", int'(tx_ready), 1);
        chk("midrst_done", int'(done), 0);
        wait_frames(5);
        push_frame("ZZXXYZXYZY", 0, 1, 0);
        send(8'h26, 1, 1, 0, a1);
        wait_frames(6);

        // Back-to-back: second frame offered in the done cycle
        push_frame("ZZXXYZXYZY", 0, 1, 0);
        push_frame("ZZXXYZXYZY", 0, 1, 0);
        send(8'h26, 1, 1, 0, a1);
        n = 0;
        while (done !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_done_seen", int'(done), 1);
        send(8'h26, 1, 1, 0, a2);
        chk("b2b_accept_gap", int'(a2 - a1), 1281);
        @(negedge clk);
        chk("b2b_busy", int'(busy), 1);
        chk("b2b_sof_low", int'(miller_out), 0);
        wait_frames(8);

        chk("sym_queue_empty", sym_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
